// File: rtl/bus_tristate_arbiter_if.sv
// Signal bundle between the bus arbiter and its requesters / tri-state enable bank.
// master is the arbiter side; slave is the requester / buffer side.
interface bus_tristate_arbiter_if #(
   parameter int N_REQ = 4
) ();
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] oe_n;
   logic [OW-1:0]    owner;
   logic             busy;

   modport master (
      input  req,
      output gnt,
      output oe_n,
      output owner,
      output busy
   );

   modport slave (
      output req,
      input  gnt,
      input  oe_n,
      input  owner,
      input  busy
   );
endinterface

// File: rtl/bus_tristate_arbiter.sv
// Round-robin owner selection for a tri-state shared bus with active-low enables,
// holding a break-before-make turnaround of TURN_CYCLES idle cycles between owners.
module bus_tristate_arbiter #(
   parameter int N_REQ       = 4,
   parameter int MAX_HOLD    = 8,
   parameter int TURN_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   bus_tristate_arbiter_if.master        bus
);
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
   localparam logic [OW-1:0] IDX_LAST  = OW'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_TURN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    ptr_q, ptr_d;
   logic [HW-1:0]    hcnt_q, hcnt_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] oe_n_q, oe_n_d;
   logic             busy_q, busy_d;

   logic [OW-1:0]    winner;
   logic [OW-1:0]    ptr_after_win;
   logic [N_REQ-1:0] others_mask;
   logic             any_req;
   logic             others_req;
   logic             owner_req;
   logic             release_bus;

   // Rotating priority search: scanning from the far end lets the index closest to ptr win.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (bus.req[idx]) begin
            winner = OW'(idx);
         end
      end
   end

   always_comb begin
      ptr_after_win = (winner == IDX_LAST) ? '0 : winner + OW'(1);
   end

   always_comb begin
      others_mask = bus.req & ~(N_REQ'(1) << owner_q);
      any_req     = |bus.req;
      others_req  = |others_mask;
      owner_req   = bus.req[owner_q];
      // A drop and a preemption on the same edge collapse into this single release.
      release_bus = !owner_req || ((hcnt_q == HOLD_LAST) && others_req);
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hcnt_d  = hcnt_q;
      tcnt_d  = tcnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d = S_GRANT;
               owner_d = winner;
               ptr_d   = ptr_after_win;
               hcnt_d  = '0;
            end
         end

         S_GRANT: begin
            if (release_bus) begin
               state_d = S_TURN;
               tcnt_d  = '0;
            end else if (hcnt_q != HOLD_LAST) begin
               hcnt_d = hcnt_q + HW'(1);
            end
         end

         S_TURN: begin
            // Requests are only looked at on the final turnaround cycle.
            if (tcnt_q == TURN_LAST) begin
               if (any_req) begin
                  state_d = S_GRANT;
                  owner_d = winner;
                  ptr_d   = ptr_after_win;
                  hcnt_d  = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      gnt_d  = '0;
      busy_d = 1'b0;
      if (state_d == S_GRANT) begin
         gnt_d  = N_REQ'(1) << owner_d;
         busy_d = 1'b1;
      end
      oe_n_d = ~gnt_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         hcnt_q  <= '0;
         tcnt_q  <= '0;
         gnt_q   <= '0;
         oe_n_q  <= '1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hcnt_q  <= hcnt_d;
         tcnt_q  <= tcnt_d;
         gnt_q   <= gnt_d;
         oe_n_q  <= oe_n_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.oe_n  = oe_n_q;
   assign bus.owner = owner_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_bus_tristate_arbiter.sv
// Bench for bus_tristate_arbiter: vector table, directed corner sequences and a
// randomized run against an ownership-level reference model.
module tb_bus_tristate_arbiter;
   localparam int N      = 4;
   localparam int MH     = 8;
   localparam int TURN_A = 1;
   localparam int TURN_B = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n;
   logic rst_b_n;

   bus_tristate_arbiter_if #(.N_REQ(N)) bus_a ();
   bus_tristate_arbiter_if #(.N_REQ(N)) bus_b ();

   bus_tristate_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .TURN_CYCLES(TURN_A)) dut_a (
      .clk   (clk),
      .rst_n (rst_a_n),
      .bus   (bus_a)
   );

   bus_tristate_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .TURN_CYCLES(TURN_B)) dut_b (
      .clk   (clk),
      .rst_n (rst_b_n),
      .bus   (bus_b)
   );

   int errors = 0;
   int checks = 0;

   logic [N-1:0] prev_ga = '0;
   logic [N-1:0] prev_gb = '0;

   typedef struct {
      logic         rst_n;
      logic [N-1:0] req;
      logic [N-1:0] gnt;
      logic [N-1:0] oe_n;
      logic [1:0]   owner;
      logic         busy;
   } vec_t;

   vec_t vecs[16];

   // Reference model: who owns the bus, how many cycles they have had it,
   // how many idle turnaround cycles remain, and where the rotation resumes.
   bit m_has;
   int m_owner;
   int m_ptr;
   int m_held;
   int m_gap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic inv_check(input string tag, input logic [N-1:0] g, input logic [N-1:0] oe,
                            input logic b, input logic [N-1:0] prev);
      logic [N-1:0] ng;
      ng = ~g;
      chk({tag, "_oe_eq_not_gnt"}, 32'(oe), 32'(ng));
      chk({tag, "_onehot"}, 32'($onehot0(g)), 32'd1);
      chk({tag, "_busy_eq_gnt"}, 32'(b), 32'(|g));
      if (prev != '0 && g != '0) begin
         chk({tag, "_no_direct_handover"}, 32'(g), 32'(prev));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      inv_check("inv_a", bus_a.gnt, bus_a.oe_n, bus_a.busy, prev_ga);
      inv_check("inv_b", bus_b.gnt, bus_b.oe_n, bus_b.busy, prev_gb);
      prev_ga = bus_a.gnt;
      prev_gb = bus_b.gnt;
   endtask

   task automatic model_grant(input logic [N-1:0] q);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (q[i]) begin
            m_owner = i;
            m_ptr   = (i + 1) % N;
            m_has   = 1'b1;
            m_held  = 1;
            return;
         end
      end
   endtask

   task automatic model_step(input logic r, input logic [N-1:0] q);
      logic [N-1:0] oth;
      if (!r) begin
         m_has = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0; m_gap = 0;
      end else if (m_has) begin
         oth = q & ~(4'b0001 << m_owner);
         if (!q[m_owner] || (m_held >= MH && oth != '0)) begin
            m_has = 1'b0;
            m_gap = TURN_A;
         end else begin
            m_held++;
         end
      end else if (m_gap > 1) begin
         m_gap--;
      end else begin
         m_gap = 0;
         if (q != '0) model_grant(q);
      end
   endtask

   initial begin
      logic [N-1:0] e;
      logic [N-1:0] rq;
      logic         rr;

      rst_a_n   = 1'b0;
      rst_b_n   = 1'b0;
      bus_a.req = '0;
      bus_b.req = '0;

      vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 2'd0, 1'b0};
      vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 2'd0, 1'b0};
      vecs[2]  = '{1'b1, 4'b0001, 4'b0001, 4'b1110, 2'd0, 1'b1};
      vecs[3]  = '{1'b1, 4'b0001, 4'b0001, 4'b1110, 2'd0, 1'b1};
      vecs[4]  = '{1'b1, 4'b0001, 4'b0001, 4'b1110, 2'd0, 1'b1};
      vecs[5]  = '{1'b1, 4'b0001, 4'b0001, 4'b1110, 2'd0, 1'b1};
      vecs[6]  = '{1'b1, 4'b0001, 4'b0001, 4'b1110, 2'd0, 1'b1};
      vecs[7]  = '{1'b1, 4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0};
      vecs[8]  = '{1'b1, 4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0};
      vecs[9]  = '{1'b1, 4'b0010, 4'b0010, 4'b1101, 2'd1, 1'b1};
      vecs[10] = '{1'b1, 4'b0011, 4'b0010, 4'b1101, 2'd1, 1'b1};
      vecs[11] = '{1'b1, 4'b0001, 4'b0000, 4'b1111, 2'd1, 1'b0};
      vecs[12] = '{1'b1, 4'b0011, 4'b0001, 4'b1110, 2'd0, 1'b1};
      vecs[13] = '{1'b1, 4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0};
      vecs[14] = '{1'b1, 4'b1000, 4'b1000, 4'b0111, 2'd3, 1'b1};
      vecs[15] = '{1'b0, 4'b1000, 4'b0000, 4'b1111, 2'd0, 1'b0};

      // Table: reset, single request, rotation after a drop, late request in TURN, reset.
      for (int v = 0; v < 16; v++) begin
         @(negedge clk);
         rst_a_n   = vecs[v].rst_n;
         bus_a.req = vecs[v].req;
         tick();
         chk($sformatf("vec%0d_gnt", v),   32'(bus_a.gnt),   32'(vecs[v].gnt));
         chk($sformatf("vec%0d_oe_n", v),  32'(bus_a.oe_n),  32'(vecs[v].oe_n));
         chk($sformatf("vec%0d_owner", v), 32'(bus_a.owner), 32'(vecs[v].owner));
         chk($sformatf("vec%0d_busy", v),  32'(bus_a.busy),  32'(vecs[v].busy));
      end

      // Round robin with all requesting: 0,1,2,3,0 for MH cycles each, one idle cycle between.
      @(negedge clk);
      rst_a_n   = 1'b1;
      bus_a.req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         e = 4'b0001 << (g % N);
         for (int c = 0; c < MH; c++) begin
            tick();
            chk($sformatf("rr%0d_c%0d_gnt", g, c), 32'(bus_a.gnt), 32'(e));
         end
         chk($sformatf("rr%0d_owner", g), 32'(bus_a.owner), 32'(g % N));
         if (g < 4) begin
            tick();
            chk($sformatf("rr%0d_gap_oe_n", g), 32'(bus_a.oe_n), 32'hF);
         end
      end

      // Lone requester is never preempted.
      @(negedge clk);
      rst_a_n   = 1'b0;
      tick();
      @(negedge clk);
      rst_a_n   = 1'b1;
      bus_a.req = 4'b0100;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk($sformatf("lone_c%0d_gnt", c), 32'(bus_a.gnt), 32'h4);
         chk($sformatf("lone_c%0d_busy", c), 32'(bus_a.busy), 32'h1);
      end

      // Three-cycle turnaround on dut_b.
      @(negedge clk);
      rst_b_n   = 1'b1;
      bus_b.req = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("turn3_owner1_gnt", 32'(bus_b.gnt), 32'h2);
      end
      @(negedge clk);
      bus_b.req = 4'b0100;
      for (int c = 0; c < TURN_B; c++) begin
         tick();
         chk($sformatf("turn3_gap%0d_oe_n", c), 32'(bus_b.oe_n), 32'hF);
         chk($sformatf("turn3_gap%0d_busy", c), 32'(bus_b.busy), 32'h0);
      end
      tick();
      chk("turn3_next_gnt", 32'(bus_b.gnt), 32'h4);
      chk("turn3_next_owner", 32'(bus_b.owner), 32'h2);

      // Reset in the middle of a grant clears outputs at once and restarts the rotation at 0.
      @(negedge clk);
      rst_a_n   = 1'b0;
      tick();
      @(negedge clk);
      rst_a_n   = 1'b1;
      bus_a.req = 4'b0010;
      for (int c = 0; c < 5; c++) tick();
      chk("midrst_pre_gnt", 32'(bus_a.gnt), 32'h2);
      @(negedge clk);
      rst_a_n   = 1'b0;
      bus_a.req = 4'b1111;
      tick();
      chk("midrst_gnt", 32'(bus_a.gnt), 32'h0);
      chk("midrst_oe_n", 32'(bus_a.oe_n), 32'hF);
      chk("midrst_owner", 32'(bus_a.owner), 32'h0);
      chk("midrst_busy", 32'(bus_a.busy), 32'h0);
      @(negedge clk);
      rst_a_n = 1'b1;
      tick();
      chk("midrst_regrant_gnt", 32'(bus_a.gnt), 32'h1);
      chk("midrst_regrant_owner", 32'(bus_a.owner), 32'h0);

      // Randomized traffic against the reference model.
      @(negedge clk);
      rst_a_n = 1'b0;
      model_step(1'b0, bus_a.req);
      tick();
      rq = '0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         rr = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
         rst_a_n   = rr;
         bus_a.req = rq;
         model_step(rr, rq);
         tick();
         e = m_has ? (4'b0001 << m_owner) : 4'b0000;
         chk($sformatf("rand%0d_gnt", c),   32'(bus_a.gnt),   32'(e));
         chk($sformatf("rand%0d_owner", c), 32'(bus_a.owner), 32'(m_owner));
         chk($sformatf("rand%0d_busy", c),  32'(bus_a.busy),  32'(m_has));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
